// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's D-cache port.
//
// A single-ported word array behind a two-stage request pipeline:
//   s1: kill, misalign and range checks; synchronous array read.
//   s2: byte-masked store write, or load data extraction; the tagged
//       response is presented in this stage.
// After reset the FSM sits in INIT and zeroes one word per cycle, and only
// then raises req_ready.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   dmem_req_valid_i/ready_o      request handshake (ready = 1 in RUN)
//   dmem_req_cmd_i                1 = store, anything else = load
//   dmem_op_type_i                [1:0] size B/H/W/D, [2] unsigned
//   dmem_req_bits_addr/data/tag_i byte address, LSB-aligned store data, tag
//   dmem_req_bits_kill_i          cancels the request accepted last cycle
//   dmem_resp_*_o                 tagged response, two cycles after accept
//   dmem_ordered_o                nothing in flight and RUN
//   dmem_xcpt_{ma,pf}_{ld,st}_o   one-cycle misalign / out-of-range pulses
module dmem_responder #(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_req_valid_i,
  output logic              dmem_req_ready_o,
  input  logic [4:0]        dmem_req_cmd_i,
  input  logic [2:0]        dmem_op_type_i,
  input  logic [ADDR_W-1:0] dmem_req_bits_addr_i,
  input  logic [DATA_W-1:0] dmem_req_bits_data_i,
  input  logic [7:0]        dmem_req_bits_tag_i,
  input  logic              dmem_req_bits_kill_i,
  output logic              dmem_resp_valid_o,
  output logic [7:0]        dmem_resp_bits_tag_o,
  output logic [DATA_W-1:0] dmem_resp_bits_data_o,
  output logic [DATA_W-1:0] dmem_resp_bits_data_subw_o,
  output logic              dmem_resp_bits_has_data_o,
  output logic              dmem_resp_bits_nack_o,
  output logic              dmem_ordered_o,
  output logic              dmem_xcpt_ma_ld_o,
  output logic              dmem_xcpt_ma_st_o,
  output logic              dmem_xcpt_pf_ld_o,
  output logic              dmem_xcpt_pf_st_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic              is_store;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        tag;
  } s1_t;

  typedef struct packed {
    logic              is_store;
    logic [1:0]        size;
    logic              uns;
    logic              nack;
    logic [2:0]        off;
    idx_t              idx;
    logic [DATA_W-1:0] data;
    logic [7:0]        tag;
  } s2_t;

  state_e            state_q, state_d;
  idx_t              cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d;
  s1_t               s1_q, s1_d;
  logic              s2_valid_q, s2_valid_d;
  s2_t               s2_q, s2_d;
  logic [DATA_W-1:0] s2_rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  idx_t              s1_idx;
  logic              s1_live, s1_misalign, s1_oob, s1_pass;
  logic              wr_en;
  idx_t              wr_idx;
  logic [7:0]        wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] shifted, ld_data, ld_subw;

  assign s1_idx = s1_q.addr[DEPTH_LOG2+2:3];

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    wr_en      = 1'b0;
    wr_idx     = cnt_q;
    wr_be      = '0;
    wr_data    = '0;
    ld_data    = '0;
    ld_subw    = '0;

    // INIT clears one word per cycle; RUN is entered as the counter wraps.
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      wr_en = 1'b1;
      wr_be = '1;
      if (cnt_q == '1) state_d = ST_RUN;
    end

    dmem_req_ready_o = (state_q == ST_RUN);
    accept           = dmem_req_valid_i && dmem_req_ready_o;

    s1_valid_d = accept;
    if (accept) begin
      s1_d.is_store = (dmem_req_cmd_i == 5'd1);
      s1_d.size     = dmem_op_type_i[1:0];
      s1_d.uns      = dmem_op_type_i[2];
      s1_d.addr     = dmem_req_bits_addr_i;
      s1_d.data     = dmem_req_bits_data_i;
      s1_d.tag      = dmem_req_bits_tag_i;
    end

    // s1 checks. Misalign masks the page fault.
    unique case (s1_q.size)
      2'd0:    s1_misalign = 1'b0;
      2'd1:    s1_misalign = s1_q.addr[0];
      2'd2:    s1_misalign = |s1_q.addr[1:0];
      default: s1_misalign = |s1_q.addr[2:0];
    endcase
    s1_oob  = |s1_q.addr[ADDR_W-1:DEPTH_LOG2+3];
    s1_live = s1_valid_q && !dmem_req_bits_kill_i;
    s1_pass = s1_live && !s1_misalign && !s1_oob;

    dmem_xcpt_ma_ld_o = s1_live && s1_misalign && !s1_q.is_store;
    dmem_xcpt_ma_st_o = s1_live && s1_misalign &&  s1_q.is_store;
    dmem_xcpt_pf_ld_o = s1_live && !s1_misalign && s1_oob && !s1_q.is_store;
    dmem_xcpt_pf_st_o = s1_live && !s1_misalign && s1_oob &&  s1_q.is_store;

    s2_valid_d = s1_pass;
    if (s1_pass) begin
      s2_d.is_store = s1_q.is_store;
      s2_d.size     = s1_q.size;
      s2_d.uns      = s1_q.uns;
      s2_d.off      = s1_q.addr[2:0];
      s2_d.idx      = s1_idx;
      s2_d.data     = s1_q.data;
      s2_d.tag      = s1_q.tag;
      // The s1 read sees the array before the s2 store lands, so a load
      // racing a store to the same word would return stale data.
      s2_d.nack     = !s1_q.is_store && s2_valid_q && s2_q.is_store &&
                      (s2_q.idx == s1_idx);
    end

    // s2 store: shift data and byte mask up to the byte offset.
    if (state_q == ST_RUN && s2_valid_q && s2_q.is_store) begin
      wr_en   = 1'b1;
      wr_idx  = s2_q.idx;
      unique case (s2_q.size)
        2'd0:    wr_be = 8'h01 << s2_q.off;
        2'd1:    wr_be = 8'h03 << s2_q.off;
        2'd2:    wr_be = 8'h0F << s2_q.off;
        default: wr_be = 8'hFF;
      endcase
      wr_data = s2_q.data << {s2_q.off, 3'b000};
    end

    // s2 load: shift down, clear above the access size, then extend.
    shifted = s2_rdata_q >> {s2_q.off, 3'b000};
    unique case (s2_q.size)
      2'd0: begin
        ld_data = {56'd0, shifted[7:0]};
        ld_subw = {{56{shifted[7] & ~s2_q.uns}}, shifted[7:0]};
      end
      2'd1: begin
        ld_data = {48'd0, shifted[15:0]};
        ld_subw = {{48{shifted[15] & ~s2_q.uns}}, shifted[15:0]};
      end
      2'd2: begin
        ld_data = {32'd0, shifted[31:0]};
        ld_subw = {{32{shifted[31] & ~s2_q.uns}}, shifted[31:0]};
      end
      default: begin
        ld_data = shifted;
        ld_subw = shifted;
      end
    endcase

    dmem_resp_valid_o          = s2_valid_q;
    dmem_resp_bits_tag_o       = s2_valid_q ? s2_q.tag : 8'd0;
    dmem_resp_bits_nack_o      = s2_valid_q && s2_q.nack;
    dmem_resp_bits_has_data_o  = s2_valid_q && !s2_q.is_store && !s2_q.nack;
    dmem_resp_bits_data_o      = dmem_resp_bits_has_data_o ? ld_data : '0;
    dmem_resp_bits_data_subw_o = dmem_resp_bits_has_data_o ? ld_subw : '0;
    dmem_ordered_o             = !s1_valid_q && !s2_valid_q && (state_q == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  // NOTE: the array has no reset; INIT zeroes it word by word, and the read
  // register is only observed behind s2_valid_q.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    s2_rdata_q <= mem_q[s1_idx];
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's D-cache request/response interface; accepts loads and stores and returns tagged responses with a fixed latency.
- Used as an on-chip data scratchpad and as the DMEM endpoint in core-level simulation, replacing the SoC cache.
- Supports kill, nack, misalign and page-fault signalling, byte-masked stores, and subword load extension.
- Clears its storage after reset before it accepts any request.

Parameters:
- ADDR_W, 40, request address width.
- DATA_W, 64, data width; fixed at 64.
- DEPTH_LOG2, 10, log2 of the number of 64-bit words stored.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous assert, active-low.
- DMEM_REQ_VALID  in  1  request valid.
- DMEM_REQ_READY  out  1  responder can accept a request.
- DMEM_REQ_CMD  in  5  0 = load (XRD), 1 = store (XWR); any other value is treated as a load.
- DMEM_OP_TYPE  in  3  [1:0] size (0 = B, 1 = H, 2 = W, 3 = D); [2] = unsigned.
- DMEM_REQ_BITS_ADDR  in  ADDR_W  byte address.
- DMEM_REQ_BITS_DATA  in  64  store data, LSB-aligned.
- DMEM_REQ_BITS_TAG  in  8  request tag.
- DMEM_REQ_BITS_KILL  in  1  kills the request accepted in the previous cycle.
- DMEM_RESP_VALID  out  1  response valid.
- DMEM_RESP_BITS_TAG  out  8  response tag.
- DMEM_RESP_BITS_DATA  out  64  load data shifted down to the LSB, no extension.
- DMEM_RESP_BITS_DATA_SUBW  out  64  load data sign/zero-extended per type.
- DMEM_RESP_BITS_HAS_DATA  out  1  response carries load data.
- DMEM_RESP_BITS_NACK  out  1  request rejected; the core must reissue it.
- DMEM_ORDERED  out  1  no request in flight.
- DMEM_XCPT_MA_LD / DMEM_XCPT_MA_ST  out  1 each  misaligned load / store.
- DMEM_XCPT_PF_LD / DMEM_XCPT_PF_ST  out  1 each  out-of-range load / store.

Behaviour:
- Reset: while RST = 0, every output is 0, all stage valids are cleared and the FSM is forced to INIT. Reset applied mid-operation drops all in-flight requests without any response.
- FSM INIT:
  - A DEPTH_LOG2-bit counter writes zero to one word per cycle, taking 2^DEPTH_LOG2 cycles.
  - READY = 0 throughout INIT.
  - When the counter wraps to 0, the FSM moves to RUN.
- FSM RUN: READY = 1 constantly; there is no other backpressure.
- Accept: a request is accepted when VALID && READY in cycle N. CMD, TYPE, ADDR, DATA and TAG are captured into stage s1.
- Cycle N+1 (s1):
  - KILL is sampled; KILL = 1 cancels the s1 request entirely: no response, no store, no exception.
  - Misalign check: ADDR mod (1 << size) ≠ 0 pulses XCPT_MA_LD or XCPT_MA_ST for one cycle. The request is then dropped: no response, no write.
  - Range check: ADDR[ADDR_W-1:3] ≥ 2^DEPTH_LOG2 pulses XCPT_PF_LD or XCPT_PF_ST for one cycle and drops the request.
  - Misalign takes priority over page fault.
  - Surviving requests read the array word at ADDR[DEPTH_LOG2+2:3] and advance to s2.
- Cycle N+2 (s2), store:
  - Writes the bytes selected by size and ADDR[2:0]; the data is shifted left by 8 × ADDR[2:0].
  - Asserts RESP_VALID with TAG and HAS_DATA = 0.
- Cycle N+2 (s2), load:
  - Asserts RESP_VALID, HAS_DATA = 1, TAG.
  - DATA = word >> (8 × ADDR[2:0]), with bits above the access size zeroed.
  - DATA_SUBW = DATA sign-extended from bit (8 << size) − 1 when TYPE[2] = 0, otherwise zero-extended. Size D is unchanged.
- Hazard:
  - If the s1 request is a load and the s2 request in the same cycle is a store to the same word index, the load is marked nack.
  - At its s2 the load gives RESP_VALID = 1, NACK = 1, HAS_DATA = 0, DATA = 0.
  - Back-to-back stores never nack.
- Throughput: one request per cycle. Responses come out in acceptance order; tags are not checked for uniqueness.
- ORDERED = !s1_valid && !s2_valid && FSM == RUN.
- Simultaneous events: a kill of the s1 request and a new accept in the same cycle are independent. The new request enters s1 normally.

Test Plan:
- Release reset, DEPTH_LOG2 = 4 → READY = 0 for 16 cycles, then 1; ORDERED rises with READY. A load of addr 0x40 then returns DATA = 0, HAS_DATA = 1.
- Store D 0x1122334455667788 @0x8 tag 3, then load B signed @0xF tag 4 → tag-3 response at N+2 with HAS_DATA = 0. Tag-4 response gives DATA = 0x11, SUBW = 0x11. After storing 0x80 to byte 0xF, a signed B load gives SUBW = 0xFFFFFFFFFFFFFF80 and an unsigned one gives 0x80.
- Store W @0x10 in cycle N, load W @0x14 in cycle N+1 → load response at N+3 with NACK = 1, HAS_DATA = 0. Reissuing the load returns the stored word.
- Load H @0x3 → XCPT_MA_LD pulses in cycle N+1, no RESP_VALID. Load D @0x80 with DEPTH_LOG2 = 4 → XCPT_PF_LD pulses and no response.
- Store @0x20 then KILL = 1 in the next cycle → no response; a later load of @0x20 returns the old data.
- Drop RST while two requests are in flight → all outputs are 0 immediately. After release, INIT reruns and no stale responses appear.
